// File: rtl/pc1_pkg.sv
// Shared types and constants for the pc1 instruction-fetch slice.
`timescale 1ns/1ps

package pc1_pkg;

   // Default datapath geometry.
   localparam int unsigned ADDR_W_DFLT    = 11;
   localparam int unsigned INSTR_W_DFLT   = 14;
   localparam int unsigned ROM_DEPTH_DFLT = 2048;

   typedef logic [ADDR_W_DFLT-1:0]  addr_t;
   typedef logic [INSTR_W_DFLT-1:0] instr_t;

   // Fetch controller: one state per register transfer.
   typedef enum logic [1:0] {
      S_MAR = 2'd0,
      S_PC  = 2'd1,
      S_IR  = 2'd2
   } fetch_state_t;

   // Upper bits of every word in the built-in ROM pattern.
   localparam logic [2:0] ROM_TAG = 3'b101;

   // Built-in ROM word for a given address: tag above the address itself.
   function automatic instr_t rom_pattern(input addr_t addr);
      return {ROM_TAG, addr};
   endfunction

endpackage

// File: rtl/pc1_rom.sv
// Asynchronous-read instruction ROM.
// Macro PC1_ROM_FILE_EN: when defined, contents come from the ROM_INIT image
// (words not set in the image read as 0); otherwise every word is
// {ROM_TAG, address}.
`timescale 1ns/1ps

module pc1_rom
   import pc1_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DFLT,
   parameter int unsigned INSTR_W   = INSTR_W_DFLT,
   parameter int unsigned ROM_DEPTH = ROM_DEPTH_DFLT
`ifdef PC1_ROM_FILE_EN
   ,
   parameter string       ROM_FILE  = "rom.hex",
   parameter logic [INSTR_W-1:0] ROM_INIT [ROM_DEPTH] = '{default: '0}
`endif
) (
   input  logic [ADDR_W-1:0]  addr_i,
   output logic [INSTR_W-1:0] data_o
);

`ifdef PC1_ROM_FILE_EN

   logic [ADDR_W-1:0] word_addr;

   // Combinational read of the addressed word.
   always_comb begin
      word_addr = ADDR_W'(32'(addr_i) % ROM_DEPTH);
      data_o    = ROM_INIT[word_addr];
   end

`else

   logic [ADDR_W-1:0] word_addr;

   // Fold the address into the array depth, then build {tag, address}.
   always_comb begin
      word_addr                 = ADDR_W'(32'(addr_i) % ROM_DEPTH);
      data_o                    = '0;
      data_o[ADDR_W-1:0]        = word_addr;
      data_o[INSTR_W-1 -: 3]    = ROM_TAG;
   end

`endif

endmodule

// File: rtl/pc1_fetch.sv
// Self-running instruction fetch: PC -> MAR -> ROM -> IR, sequenced by a
// three-state Moore controller. All registers and strobes are exported.
// Macro PC1_ROM_FILE_EN selects an image-initialised ROM (see pc1_rom).
`timescale 1ns/1ps

module pc1_fetch
   import pc1_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DFLT,
   parameter int unsigned INSTR_W   = INSTR_W_DFLT,
   parameter int unsigned ROM_DEPTH = ROM_DEPTH_DFLT
`ifdef PC1_ROM_FILE_EN
   ,
   parameter string       ROM_FILE  = "rom.hex",
   parameter logic [INSTR_W-1:0] ROM_INIT [ROM_DEPTH] = '{default: '0}
`endif
) (
   input  logic               clk,
   input  logic               rst,
   output logic               load_ir,
   output logic               load_mar,
   output logic               load_pc,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  rom_in,
   output logic [ADDR_W-1:0]  rom_out,
   output logic [INSTR_W-1:0] ir
);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  mar_q, mar_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [INSTR_W-1:0] rom_data;

   // Controller state register; reset parks it in S_MAR.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_MAR;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and Moore strobes: exactly one strobe per state.
   always_comb begin
      state_d  = state_q;
      load_mar = 1'b0;
      load_pc  = 1'b0;
      load_ir  = 1'b0;
      unique case (state_q)
         S_MAR: begin
            load_mar = 1'b1;
            state_d  = S_PC;
         end
         S_PC: begin
            load_pc = 1'b1;
            state_d = S_IR;
         end
         S_IR: begin
            load_ir = 1'b1;
            state_d = S_MAR;
         end
         default: begin
            // Unused encoding: recover to the start of a fetch.
            state_d = S_MAR;
         end
      endcase
   end

   // Datapath next-state: each register holds unless its strobe is high.
   always_comb begin
      pc_d  = pc_q;
      mar_d = mar_q;
      ir_d  = ir_q;
      if (load_mar) begin
         mar_d = pc_q;
      end
      if (load_pc) begin
         // Natural wrap from all-ones back to zero.
         pc_d = pc_q + ADDR_W'(1);
      end
      if (load_ir) begin
         ir_d = rom_data;
      end
   end

   // Datapath registers; an asynchronous reset discards any partial fetch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q  <= '0;
         mar_q <= '0;
         ir_q  <= '0;
      end else begin
         pc_q  <= pc_d;
         mar_q <= mar_d;
         ir_q  <= ir_d;
      end
   end

   pc1_rom #(
      .ADDR_W    (ADDR_W),
      .INSTR_W   (INSTR_W),
`ifdef PC1_ROM_FILE_EN
      .ROM_FILE  (ROM_FILE),
      .ROM_INIT  (ROM_INIT),
`endif
      .ROM_DEPTH (ROM_DEPTH)
   ) u_rom (
      .addr_i (mar_q),
      .data_o (rom_data)
   );

   // Observation outputs; only the low address-width bits of the word leave.
   always_comb begin
      pc      = pc_q;
      rom_in  = mar_q;
      rom_out = rom_data[ADDR_W-1:0];
      ir      = ir_q;
   end

endmodule

// File: tb/tb_pc1_fetch.sv
// Self-checking bench for pc1_fetch against an edge-count reference model.
`timescale 1ns/1ps

module tb_pc1_fetch;

   logic        clk;
   logic        rst;
   logic        load_ir;
   logic        load_mar;
   logic        load_pc;
   logic [10:0] pc;
   logic [10:0] rom_in;
   logic [10:0] rom_out;
   logic [13:0] ir;

   int n_checks = 0;
   int n_pass   = 0;
   int k;  // rising edges since the last reset release

   // Packed view of everything observable: {strobes(ir,pc,mar), pc, mar, rom_out, ir}.
   logic [49:0] obs;
   assign obs = {load_ir, load_pc, load_mar, pc, rom_in, rom_out, ir};

   localparam logic [49:0] RESET_OBS = {3'b001, 11'h000, 11'h000, 11'h000, 14'h0000};

`ifdef PC1_ROM_FILE_EN
   localparam logic [13:0] TB_ROM_IMAGE [2048] = '{0: 14'h1234, 1: 14'h3FFF, default: 14'h0000};

   pc1_fetch #(
      .ROM_INIT (TB_ROM_IMAGE)
   ) dut (
`else
   pc1_fetch dut (
`endif
      .clk      (clk),
      .rst      (rst),
      .load_ir  (load_ir),
      .load_mar (load_mar),
      .load_pc  (load_pc),
      .pc       (pc),
      .rom_in   (rom_in),
      .rom_out  (rom_out),
      .ir       (ir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) k <= 0;
      else      k <= k + 1;
   end

   // Reference ROM contents.
   function automatic logic [13:0] rom_word(input int a);
`ifdef PC1_ROM_FILE_EN
      case (a)
         0:       return 14'h1234;
         1:       return 14'h3FFF;
         default: return 14'h0000;
      endcase
`else
      return 14'h2800 | 14'(a % 2048);
`endif
   endfunction

   // Expected observation after kk edges: counts how many MAR loads, PC
   // increments and IR loads have happened so far in a 3-cycle fetch cadence.
   function automatic logic [49:0] expect_at(input int kk);
      int          mar_loads, pc_incs, ir_loads;
      logic [10:0] e_pc, e_mar;
      logic [13:0] e_ir, w;
      logic [2:0]  e_st;
      mar_loads = (kk + 2) / 3;
      pc_incs   = (kk + 1) / 3;
      ir_loads  = kk / 3;
      e_mar = (mar_loads == 0) ? 11'd0 : 11'((mar_loads - 1) % 2048);
      e_pc  = 11'(pc_incs % 2048);
      e_ir  = (ir_loads == 0) ? 14'd0 : rom_word((ir_loads - 1) % 2048);
      e_st  = 3'b001 << (kk % 3);
      w     = rom_word(int'(e_mar));
      return {e_st, e_pc, e_mar, w[10:0], e_ir};
   endfunction

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== RESET_OBS)
            $display("FAIL reset_hold cyc=%0d got %h expected %h", i, obs, RESET_OBS);
         else n_pass++;
      end
   endtask

   task automatic test_release();
      rst = 1'b1;  // at a negedge
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         n_checks++;
         if ({load_ir, load_pc, load_mar} !== (3'b001 << (i % 3)))
            $display("FAIL strobe_seq edge=%0d got %b expected %b", i,
                     {load_ir, load_pc, load_mar}, 3'b001 << (i % 3));
         else n_pass++;
         if (i == 3) begin
            n_checks++;
            if ({pc, rom_in, ir} !== {11'd1, 11'd0, rom_word(0)})
               $display("FAIL first_fetch got pc=%h mar=%h ir=%h expected pc=001 mar=000 ir=%h",
                        pc, rom_in, ir, rom_word(0));
            else n_pass++;
         end
      end
   endtask

   task automatic test_steady();
      logic [49:0] e;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         e = expect_at(k);
         n_checks++;
         if (obs !== e) $display("FAIL steady k=%0d got %h expected %h", k, obs, e);
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      logic [49:0] e;
      do_reset($urandom_range(1, 4));
      for (int i = 1; i <= 3 * 2048 + 3; i++) begin
         @(negedge clk);
         e = expect_at(k);
         n_checks++;
         if (obs !== e) $display("FAIL wrap k=%0d got %h expected %h", k, obs, e);
         else n_pass++;
         if (i == 3 * 2047 + 3) begin
            n_checks++;
            if ({ir, pc} !== {rom_word(2047), 11'd0})
               $display("FAIL wrap_last got ir=%h pc=%h expected ir=%h pc=000",
                        ir, pc, rom_word(2047));
            else n_pass++;
         end
         if (i == 3 * 2048 + 3) begin
            n_checks++;
            if ({rom_in, ir} !== {11'd0, rom_word(0)})
               $display("FAIL wrap_next got mar=%h ir=%h expected mar=000 ir=%h",
                        rom_in, ir, rom_word(0));
            else n_pass++;
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset(2);
      repeat (16) @(negedge clk);
      n_checks++;
      if ({load_pc, pc} !== {1'b1, 11'd5})
         $display("FAIL mid_setup got load_pc=%b pc=%h expected load_pc=1 pc=005", load_pc, pc);
      else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (obs !== RESET_OBS) $display("FAIL mid_async_clear got %h expected %h", obs, RESET_OBS);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({pc, rom_in, ir} !== {11'd1, 11'd0, rom_word(0)})
         $display("FAIL mid_restart got pc=%h mar=%h ir=%h expected pc=001 mar=000 ir=%h",
                  pc, rom_in, ir, rom_word(0));
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [49:0] e;
      int          run;
      for (int it = 0; it < 8; it++) begin
         run = $urandom_range(0, 60);
         repeat (run) begin
            @(negedge clk);
            e = expect_at(k);
            n_checks++;
            if (obs !== e) $display("FAIL b2b_run it=%0d k=%0d got %h expected %h", it, k, obs, e);
            else n_pass++;
         end
         #($urandom_range(1, 4)) rst = 1'b0;
         #1;
         n_checks++;
         if (obs !== RESET_OBS)
            $display("FAIL b2b_clear it=%0d got %h expected %h", it, obs, RESET_OBS);
         else n_pass++;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         rst = 1'b1;
      end
      repeat (6) begin
         @(negedge clk);
         e = expect_at(k);
         n_checks++;
         if (obs !== e) $display("FAIL b2b_tail k=%0d got %h expected %h", k, obs, e);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_release();
      test_steady();
      test_wrap();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
